// File: rtl/gemm_sched_pkg.sv
// Shared definitions for the GEMM tile scheduler: gemm register offsets,
// dimension-word field positions and the scheduler state encoding.
package gemm_sched_pkg;

  localparam logic [31:0] OFF_TILE_A = 32'd0;
  localparam logic [31:0] OFF_TILE_B = 32'd4;
  localparam logic [31:0] OFF_TILE_C = 32'd8;
  localparam logic [31:0] OFF_ASTR   = 32'd12;
  localparam logic [31:0] OFF_BSTR   = 32'd16;
  localparam logic [31:0] OFF_CTRL   = 32'd20;
  localparam logic [31:0] OFF_DIM    = 32'd24;

  localparam int DIM_K_SHIFT = 5;
  localparam int DIM_N_SHIFT = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_WR_ASTR,
    S_WR_BSTR,
    S_TILE,
    S_WR_A,
    S_WR_B,
    S_WR_C,
    S_WR_CTRL,
    S_WR_DIM,
    S_POLL_FULL,
    S_FULL_SMP,
    S_ADV,
    S_POLL_DONE,
    S_DONE_SMP,
    S_FIN
  } state_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/gemm_tile_iter.sv
// n->m->k tile walker: holds the loop counters, steps them on advance and
// registers the per-tile addresses, control bits and size word on compute.
module gemm_tile_iter
  import gemm_sched_pkg::*;
#(
  parameter int BLK_M = 16,
  parameter int BLK_K = 16,
  parameter int BLK_N = 16,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             compute_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [31:0]      a_base_i,
  input  logic [31:0]      b_base_i,
  input  logic [31:0]      c_base_i,
  output logic             last_o,
  output logic [31:0]      tile_a_o,
  output logic [31:0]      tile_b_o,
  output logic [31:0]      tile_c_o,
  output logic [31:0]      ctrl_o,
  output logic [31:0]      dim_o
);

  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [DIM_W-1:0] m_d, k_d, n_d;
  logic [31:0]      m32, k32, n32, dm, dk, dn;
  logic [31:0]      msize, ksize, nsize;
  logic             k_end, m_end, n_end, first;
  logic [31:0]      tile_a_q, tile_b_q, tile_c_q, ctrl_q, dim_q;

  assign m32 = 32'(m_q);
  assign k32 = 32'(k_q);
  assign n32 = 32'(n_q);
  assign dm  = 32'(dim_m_i);
  assign dk  = 32'(dim_k_i);
  assign dn  = 32'(dim_n_i);

  // End-of-range tests are done in 32 bits so large dims cannot wrap the compare.
  assign k_end = (k32 + 32'(BLK_K)) >= dk;
  assign m_end = (m32 + 32'(BLK_M)) >= dm;
  assign n_end = (n32 + 32'(BLK_N)) >= dn;
  assign first  = (k_q == '0);
  assign last_o = k_end & m_end & n_end;

  assign msize = min_u32(32'(BLK_M), dm - m32);
  assign ksize = min_u32(32'(BLK_K), dk - k32);
  assign nsize = min_u32(32'(BLK_N), dn - n32);

  always_comb begin
    m_d = m_q;
    k_d = k_q;
    n_d = n_q;
    if (init_i) begin
      m_d = '0;
      k_d = '0;
      n_d = '0;
    end else if (adv_i) begin
      if (k_end) begin
        k_d = '0;
        if (m_end) begin
          m_d = '0;
          n_d = n_q + DIM_W'(BLK_N);
        end else begin
          m_d = m_q + DIM_W'(BLK_M);
        end
      end else begin
        k_d = k_q + DIM_W'(BLK_K);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      tile_a_q <= '0;
      tile_b_q <= '0;
      tile_c_q <= '0;
      ctrl_q   <= '0;
      dim_q    <= '0;
    end else begin
      m_q <= m_d;
      k_q <= k_d;
      n_q <= n_d;
      if (compute_i) begin
        tile_a_q <= a_base_i + m32 * dk + k32;
        // B is addressed at the last row of the tile, as the array streams it bottom-up.
        tile_b_q <= b_base_i + n32 + (k32 + ksize - 32'd1) * dn;
        tile_c_q <= c_base_i + m32 * dn + n32;
        ctrl_q   <= {30'b0, first, k_end};
        dim_q    <= (nsize << DIM_N_SHIFT) | (ksize << DIM_K_SHIFT) | msize;
      end
    end
  end

  assign tile_a_o = tile_a_q;
  assign tile_b_o = tile_b_q;
  assign tile_c_o = tile_c_q;
  assign ctrl_o   = ctrl_q;
  assign dim_o    = dim_q;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks a full GEMM job as a sequence of tiles: writes strides once, then per
// tile programs the accelerator, polls its full flag and finally polls done.
module gemm_tile_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int          BLK_M     = 16,
  parameter int          BLK_K     = 16,
  parameter int          BLK_N     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          DIM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      c_base,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      tiles_issued,
  output logic [31:0]      cycle_count,
  output logic             system_bus_en,
  output logic             system_bus_rdwr,
  output logic [31:0]      system_bus_addr,
  output logic [31:0]      system_bus_wr_data,
  input  logic [31:0]      system_bus_rd_data
);

  state_e           state_q;
  logic             busy_q, done_q, err_q;
  logic [31:0]      tiles_q, cycles_q;
  logic [DIM_W-1:0] dim_m_q, dim_k_q, dim_n_q;
  logic [31:0]      a_base_q, b_base_q, c_base_q;

  logic             iter_last;
  logic [31:0]      tile_a, tile_b, tile_c, tile_ctrl, tile_dim;
  logic             bus_wr, bus_rd;
  logic [31:0]      bus_off, bus_data;
  logic             poll_bit;
  logic             unused_rd_bits;

  assign poll_bit       = system_bus_rd_data[0];
  assign unused_rd_bits = ^system_bus_rd_data[31:1];

  gemm_tile_iter #(
    .BLK_M(BLK_M),
    .BLK_K(BLK_K),
    .BLK_N(BLK_N),
    .DIM_W(DIM_W)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .init_i    ((state_q == S_IDLE) && start),
    .compute_i (state_q == S_TILE),
    .adv_i     (state_q == S_ADV),
    .dim_m_i   (dim_m_q),
    .dim_k_i   (dim_k_q),
    .dim_n_i   (dim_n_q),
    .a_base_i  (a_base_q),
    .b_base_i  (b_base_q),
    .c_base_i  (c_base_q),
    .last_o    (iter_last),
    .tile_a_o  (tile_a),
    .tile_b_o  (tile_b),
    .tile_c_o  (tile_c),
    .ctrl_o    (tile_ctrl),
    .dim_o     (tile_dim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tiles_q  <= '0;
      cycles_q <= '0;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (busy_q) cycles_q <= cycles_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dim_m_q  <= dim_m;
            dim_k_q  <= dim_k;
            dim_n_q  <= dim_n;
            a_base_q <= a_base;
            b_base_q <= b_base;
            c_base_q <= c_base;
            busy_q   <= 1'b1;
            cycles_q <= '0;
            tiles_q  <= '0;
            state_q  <= S_CHK;
          end
        end
        S_CHK: begin
          if (dim_m_q == '0 || dim_k_q == '0 || dim_n_q == '0) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            state_q <= S_WR_ASTR;
          end
        end
        S_WR_ASTR: state_q <= S_WR_BSTR;
        S_WR_BSTR: state_q <= S_TILE;
        S_TILE:    state_q <= S_WR_A;
        S_WR_A:    state_q <= S_WR_B;
        S_WR_B:    state_q <= S_WR_C;
        S_WR_C:    state_q <= S_WR_CTRL;
        S_WR_CTRL: state_q <= S_WR_DIM;
        S_WR_DIM: begin
          tiles_q <= tiles_q + 32'd1;
          state_q <= S_POLL_FULL;
        end
        S_POLL_FULL: state_q <= S_FULL_SMP;
        S_FULL_SMP:  state_q <= poll_bit ? S_POLL_FULL : S_ADV;
        S_ADV:       state_q <= iter_last ? S_POLL_DONE : S_TILE;
        S_POLL_DONE: state_q <= S_DONE_SMP;
        S_DONE_SMP: begin
          if (poll_bit) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            state_q <= S_POLL_DONE;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus is a pure decode of the registered state and registered tile/job data.
  always_comb begin
    bus_wr   = 1'b0;
    bus_rd   = 1'b0;
    bus_off  = '0;
    bus_data = '0;
    case (state_q)
      S_WR_ASTR:   begin bus_wr = 1'b1; bus_off = OFF_ASTR;   bus_data = 32'(dim_k_q); end
      S_WR_BSTR:   begin bus_wr = 1'b1; bus_off = OFF_BSTR;   bus_data = 32'(dim_n_q); end
      S_WR_A:      begin bus_wr = 1'b1; bus_off = OFF_TILE_A; bus_data = tile_a;       end
      S_WR_B:      begin bus_wr = 1'b1; bus_off = OFF_TILE_B; bus_data = tile_b;       end
      S_WR_C:      begin bus_wr = 1'b1; bus_off = OFF_TILE_C; bus_data = tile_c;       end
      S_WR_CTRL:   begin bus_wr = 1'b1; bus_off = OFF_CTRL;   bus_data = tile_ctrl;    end
      S_WR_DIM:    begin bus_wr = 1'b1; bus_off = OFF_DIM;    bus_data = tile_dim;     end
      S_POLL_FULL: begin bus_rd = 1'b1; bus_off = OFF_TILE_A; end
      S_POLL_DONE: begin bus_rd = 1'b1; bus_off = OFF_DIM;    end
      default: ;
    endcase
  end

  assign system_bus_en      = bus_wr | bus_rd;
  assign system_bus_rdwr    = bus_wr;
  assign system_bus_addr    = (bus_wr | bus_rd) ? (BASE_ADDR + bus_off) : 32'd0;
  assign system_bus_wr_data = bus_wr ? bus_data : 32'd0;

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tiles_issued = tiles_q;
  assign cycle_count  = cycles_q;

endmodule
